// File: rtl/beam_pkg.sv
// Shared definitions for the beamformer back end: the state encoding of the
// sum accumulator, default widths shared with the delay stage, and an
// index-width helper that never returns zero.
package beam_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int OUT_W_DEF       = 32;
    localparam int ACC_W_DEF       = 40;
    localparam int NUM_SAMPLES_DEF = 64;
    localparam int NUM_POINTS_DEF  = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } beam_state_t;

    // Width needed to index n items; a single item still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEF = idx_w(NUM_SAMPLES_DEF);
    localparam int PT_W_DEF  = idx_w(NUM_POINTS_DEF);

endpackage

// File: rtl/beam_out_conv.sv
// Reduces the ACC_W-bit signed beam sum to OUT_W bits.
// Build option BEAM_SAT_EN: defined -> signed saturation to the OUT_W range;
// undefined -> the low OUT_W bits are kept (wrap-around).
module beam_out_conv
    import beam_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [ACC_W-1:0] acc_in,
    output logic [OUT_W-1:0] conv_out
);

`ifdef BEAM_SAT_EN
    localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clamp to the representable signed OUT_W range.
    always_comb begin
        if ($signed(acc_in) > $signed(SAT_MAX)) begin
            conv_out = {1'b0, {(OUT_W-1){1'b1}}};
        end else if ($signed(acc_in) < $signed(SAT_MIN)) begin
            conv_out = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            conv_out = acc_in[OUT_W-1:0];
        end
    end
`else
    logic unused_hi;

    // Plain truncation; the discarded upper bits are deliberately unused.
    always_comb begin
        conv_out  = acc_in[OUT_W-1:0];
        unused_hi = ^acc_in[ACC_W-1:OUT_W];
    end
`endif

endmodule

// File: rtl/beam_sum_accumulator.sv
// Sums NUM_SAMPLES accepted delay-stage samples per focal point and hands each
// sum out on a ready/valid port; frame_done pulses after the last point.
// Build option BEAM_SAT_EN selects saturating (vs wrapping) output reduction.
//
//   state | meaning
//   IDLE  | waiting for start; samples ignored
//   ACCUM | summing samples of the current focal point
//   EMIT  | sum presented, waiting for beam_ready
//   DONE  | frame complete, frame_done high for this cycle
module beam_sum_accumulator
    import beam_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACC_W       = ACC_W_DEF,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
    parameter int NUM_POINTS  = NUM_POINTS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DATA_W-1:0]            sample_in,
    input  logic                         sample_valid,
    output logic [OUT_W-1:0]             beam_value,
    output logic                         beam_valid,
    input  logic                         beam_ready,
    output logic [idx_w(NUM_POINTS)-1:0] point_index,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam int CNT_W = idx_w(NUM_SAMPLES);
    localparam int PT_W  = idx_w(NUM_POINTS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [PT_W-1:0]  LAST_PT  = PT_W'(NUM_POINTS - 1);

    beam_state_t       state, state_nxt;
    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [ACC_W-1:0]  sample_ext, sum_cur, conv_in;
    logic [OUT_W-1:0]  conv_out;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [PT_W-1:0]   point_nxt;
    logic [OUT_W-1:0]  beam_value_nxt;
    logic              beam_valid_nxt, frame_done_nxt, overrun_nxt, busy_nxt;

    // In EMIT a new sample starts a fresh sum, so only it is converted there.
    assign sample_ext = {{(ACC_W-DATA_W){sample_in[DATA_W-1]}}, sample_in};
    assign sum_cur    = acc + sample_ext;
    assign conv_in    = (state == EMIT) ? sample_ext : sum_cur;

    beam_out_conv #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_conv (
        .acc_in   (conv_in),
        .conv_out (conv_out)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        count_nxt      = count;
        point_nxt      = point_index;
        beam_value_nxt = beam_value;
        beam_valid_nxt = beam_valid;
        frame_done_nxt = 1'b0;
        overrun_nxt    = overrun;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = ACCUM;
                    acc_nxt     = '0;
                    count_nxt   = '0;
                    point_nxt   = '0;
                    overrun_nxt = 1'b0;
                end
            end
            ACCUM: begin
                if (!start) begin
                    state_nxt      = IDLE;
                    beam_valid_nxt = 1'b0;
                    acc_nxt        = '0;
                    count_nxt      = '0;
                    point_nxt      = '0;
                end else if (sample_valid) begin
                    if (count == LAST_CNT) begin
                        beam_value_nxt = conv_out;
                        beam_valid_nxt = 1'b1;
                        state_nxt      = EMIT;
                    end else begin
                        acc_nxt   = sum_cur;
                        count_nxt = count + 1'b1;
                    end
                end
            end
            EMIT: begin
                if (!start) begin
                    state_nxt      = IDLE;
                    beam_valid_nxt = 1'b0;
                    acc_nxt        = '0;
                    count_nxt      = '0;
                    point_nxt      = '0;
                end else if (beam_ready) begin
                    beam_valid_nxt = 1'b0;
                    if (point_index == LAST_PT) begin
                        state_nxt      = DONE;
                        frame_done_nxt = 1'b1;
                        if (sample_valid) overrun_nxt = 1'b1;
                    end else begin
                        point_nxt = point_index + 1'b1;
                        if (sample_valid) begin
                            if (NUM_SAMPLES == 1) begin
                                beam_value_nxt = conv_out;
                                beam_valid_nxt = 1'b1;
                            end else begin
                                acc_nxt   = sample_ext;
                                count_nxt = CNT_W'(1);
                                state_nxt = ACCUM;
                            end
                        end else begin
                            acc_nxt   = '0;
                            count_nxt = '0;
                            state_nxt = ACCUM;
                        end
                    end
                end else if (sample_valid) begin
                    overrun_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            count       <= '0;
            point_index <= '0;
            beam_value  <= '0;
            beam_valid  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            acc         <= acc_nxt;
            count       <= count_nxt;
            point_index <= point_nxt;
            beam_value  <= beam_value_nxt;
            beam_valid  <= beam_valid_nxt;
            busy        <= busy_nxt;
            frame_done  <= frame_done_nxt;
            overrun     <= overrun_nxt;
        end
    end

endmodule
